// File: rtl/biu_pkg.sv
// Shared types and widths for the bus interface unit and its wait/timeout timer.
package biu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } biu_state_t;

  localparam int WAIT_W      = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int TO_W        = $clog2(TIMEOUT_DEF + 1);

  // Timeout counter width for a given abort threshold.
  function automatic int to_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/biu_wait_timer.sv
// Per-strobe wait-state down-counter and mem_ready stall up-counter; reloaded on entry to ACCESS.
// timeout fires combinationally on the ACCESS edge that would make the stall count reach TIMEOUT.
module biu_wait_timer
  import biu_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64,
  parameter int TOW         = TO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  input  logic mem_ready,
  output logic expired,
  output logic timeout
);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TOW-1:0]    to_q, to_d;

  always_comb begin
    wait_d = wait_q;
    to_d   = to_q;
    if (load) begin
      wait_d = WAIT_W'(WAIT_STATES);
      to_d   = '0;
    end else if (tick) begin
      // mem_ready is only meaningful once the programmed wait states are spent
      if (wait_q != '0) begin
        wait_d = wait_q - 1'b1;
      end else if (!mem_ready) begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      to_q   <= '0;
    end else begin
      wait_q <= wait_d;
      to_q   <= to_d;
    end
  end

  assign expired = (wait_q == '0);
  assign timeout = tick && expired && !mem_ready && (to_q == TOW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_interface_unit.sv
// Sequences byte / little-endian word memory cycles for the core: SETUP, strobed ACCESS, DONE pulse.
// Byte latency W+3 edges from accept, word 2W+5; req_ready is low from accept until DONE returns to IDLE.
module bus_interface_unit
  import biu_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic        req_we,
  input  logic        req_word,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  localparam int TOW = to_w(TIMEOUT);

  biu_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        word_q, word_d;
  logic [7:0]  wdata_hi_q, wdata_hi_d;
  logic        idx_q, idx_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_oe_q, mem_oe_d;
  logic        mem_we_q, mem_we_d;
  logic        expired, timeout;

  biu_wait_timer #(
    .WAIT_STATES(WAIT_STATES),
    .TIMEOUT    (TIMEOUT),
    .TOW        (TOW)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q == SETUP),
    .tick     (state_q == ACCESS),
    .mem_ready(mem_ready),
    .expired  (expired),
    .timeout  (timeout)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    word_d      = word_q;
    wdata_hi_d  = wdata_hi_q;
    idx_d       = idx_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_oe_d    = mem_oe_q;
    mem_we_d    = mem_we_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          we_d        = req_we;
          word_d      = req_word;
          wdata_hi_d  = req_wdata[15:8];
          idx_d       = 1'b0;
          req_ready_d = 1'b0;
          mem_addr_d  = req_addr;
          mem_wdata_d = req_wdata[7:0];
          state_d     = SETUP;
        end
      end
      SETUP: begin
        mem_oe_d = !we_q;
        mem_we_d = we_q;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (expired && mem_ready) begin
          mem_oe_d = 1'b0;
          mem_we_d = 1'b0;
          if (!we_q) begin
            if (idx_q)       rsp_data_d[15:8] = mem_rdata;
            else if (word_q) rsp_data_d[7:0]  = mem_rdata;
            else             rsp_data_d       = {8'h00, mem_rdata};
          end
          if (word_q && !idx_q) begin
            // high byte address wraps at 0xFFFF, matching the AGU's 16-bit space
            idx_d       = 1'b1;
            mem_addr_d  = addr_q + 16'd1;
            mem_wdata_d = wdata_hi_q;
            state_d     = SETUP;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else if (timeout) begin
          mem_oe_d    = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      wdata_hi_q  <= '0;
      idx_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      word_q      <= word_d;
      wdata_hi_q  <= wdata_hi_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_bus_interface_unit.sv
// Scoreboarded bench: two BIUs (WAIT_STATES 0 and 1), a byte-array memory and a strobe/response monitor.
module tb_bus_interface_unit;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [15:0] req_addr  [2];
  logic        req_we    [2];
  logic        req_word  [2];
  logic [15:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [15:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];
  logic        mem_oe    [2];
  logic        mem_we    [2];
  logic [7:0]  mem_rdata [2];
  logic        mem_ready [2];
  logic [7:0]  mem [0:65535];

  // DUT index g has WAIT_STATES == g
  for (genvar g = 0; g < 2; g++) begin : g_dut
    bus_interface_unit #(.WAIT_STATES(g), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .req_we(req_we[g]), .req_word(req_word[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_data(rsp_data[g]), .rsp_err(rsp_err[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_oe(mem_oe[g]),
      .mem_we(mem_we[g]), .mem_rdata(mem_rdata[g]), .mem_ready(mem_ready[g])
    );
    assign mem_rdata[g] = mem[mem_addr[g]];
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  len;
  } cyc_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic [31:0] at;
  } rsp_t;

  cyc_t        cq[$];
  rsp_t        rq[$];
  logic [15:0] rd_m [2];
  int          act, stall, n_chk, n_err;
  int          cyc = 0;
  bit          mon_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pushes expected strobe cycles and the response, returns latency in edges.
  task automatic model(input int d, input logic [15:0] a, input logic we, input logic word,
                       input logic [15:0] wd, input int st, input int base, output int lat);
    int l;
    logic [15:0] ai;
    bit ab;
    lat = 1;
    ab  = 0;
    for (int i = 0; i < (word ? 2 : 1) && !ab; i++) begin
      ai = a + 16'(i);
      if (st >= TO) begin
        l  = d + TO;
        ab = 1;
      end else begin
        l = d + 1 + st;
      end
      cq.push_back('{ai, (i == 1) ? wd[15:8] : wd[7:0], we, 8'(l)});
      lat += 1 + l;
      if (!we && !ab) begin
        if (i == 1)    rd_m[d][15:8] = mem[ai];
        else if (word) rd_m[d][7:0]  = mem[ai];
        else           rd_m[d]       = {8'h00, mem[ai]};
      end
    end
    rq.push_back('{rd_m[d], ab, 32'(base + lat)});
  endtask

  // Strobe / response monitor; also plays the memory's mem_ready.
  int          cnt;
  logic        strb, s_we, s_both, s_moved;
  logic [15:0] s_addr;
  logic [7:0]  s_wd;
  cyc_t        ec;
  rsp_t        er;

  always @(negedge clk) begin
    if (!mon_en) begin
      cnt          = 0;
      mem_ready[0] = 1'b0;
      mem_ready[1] = 1'b0;
    end else begin
      strb = mem_oe[act] | mem_we[act];
      if (strb) begin
        if (cnt == 0) begin
          s_addr = mem_addr[act]; s_wd = mem_wdata[act]; s_we = mem_we[act];
          s_both = 1'b0; s_moved = 1'b0;
        end else if (mem_addr[act] != s_addr || mem_wdata[act] != s_wd) begin
          s_moved = 1'b1;
        end
        if (mem_oe[act] && mem_we[act]) s_both = 1'b1;
        cnt++;
      end else if (cnt != 0) begin
        if (cq.size() == 0) begin
          check("cyc_unexpected", cnt, 0);
        end else begin
          ec = cq.pop_front();
          check("cyc_addr", s_addr, ec.addr);
          check("cyc_wdata", s_wd, ec.wdata);
          check("cyc_we", s_we, ec.we);
          check("cyc_len", cnt, ec.len);
          check("cyc_both_strobes", s_both, 0);
          check("cyc_addr_stable", s_moved, 0);
        end
        cnt = 0;
      end
      mem_ready[act]     = strb && (cnt > act + stall);
      mem_ready[1 - act] = 1'b0;
      if (rsp_valid[act]) begin
        if (rq.size() == 0) begin
          check("rsp_unexpected", rsp_valid[act], 0);
        end else begin
          er = rq.pop_front();
          check("rsp_data", rsp_data[act], er.data);
          check("rsp_err", rsp_err[act], er.err);
          check("rsp_latency", cyc, er.at);
        end
      end
    end
  end

  task automatic drain(input int d);
    int t = 0;
    while (rq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("rsp_pending", rq.size(), 0);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid[d], 0);
    check("cyc_pending", cq.size(), 0);
    rq.delete();
    cq.delete();
  endtask

  task automatic issue(input int d, input logic [15:0] a, input logic we, input logic word,
                       input logic [15:0] wd, input int st);
    int lat;
    act   = d;
    stall = st;
    model(d, a, we, word, wd, st, cyc, lat);
    req_addr[d] = a; req_we[d] = we; req_word[d] = word; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    drain(d);
  endtask

  initial begin
    int lat, lat2, t;
    bit seen;
    n_chk = 0; n_err = 0; mon_en = 0; act = 1; stall = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);
    mem[16'h1234] = 8'hA5;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_addr[d] = 0; req_we[d] = 0; req_word[d] = 0; req_wdata[d] = 0;
      rd_m[d] = 16'h0000;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_err", rsp_err[d], 0);
      check("rst_rsp_data", rsp_data[d], 0);
      check("rst_mem_addr", mem_addr[d], 0);
      check("rst_strobes", {mem_oe[d], mem_we[d]}, 0);
    end
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    issue(1, 16'h1234, 1'b0, 1'b0, 16'h5A3C, 0);   // byte read, W=1
    issue(1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 0);   // word read wrapping to 0x0000
    issue(0, 16'h1234, 1'b0, 1'b0, 16'h0000, 0);   // byte read, W=0
    issue(0, 16'h2000, 1'b1, 1'b1, 16'hBEEF, 0);   // word write, rsp_data must stay 0x00A5
    issue(1, 16'h1234, 1'b0, 1'b0, 16'h0000, 5);   // mem_ready stretched 5 cycles
    issue(1, 16'h3000, 1'b0, 1'b0, 16'h0000, TO);  // byte timeout
    issue(1, 16'hFFFF, 1'b0, 1'b1, 16'h0000, TO);  // word timeout on first byte

    // back-to-back byte writes with req_valid held through DONE
    act = 1; stall = 0;
    model(1, 16'h4000, 1'b1, 1'b0, 16'h0077, 0, cyc, lat);
    model(1, 16'h4000, 1'b1, 1'b0, 16'h0077, 0, cyc + lat + 1, lat2);
    req_addr[1] = 16'h4000; req_we[1] = 1'b1; req_word[1] = 1'b0; req_wdata[1] = 16'h0077;
    req_valid[1] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid[1] && t < 100);
    check("b2b_busy_in_done", req_ready[1], 0);
    t = 0;
    while (!req_ready[1] && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    drain(1);

    // reset in the middle of a write strobe
    mon_en = 0;
    @(negedge clk);
    req_addr[1] = 16'h5555; req_we[1] = 1'b1; req_word[1] = 1'b0; req_wdata[1] = 16'h0011;
    req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_we_active", mem_we[1], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_we", mem_we[1], 0);
    check("mid_rst_ready", req_ready[1], 1);
    check("mid_rst_rsp_valid", rsp_valid[1], 0);
    check("mid_rst_rsp_data", rsp_data[1], 0);
    rd_m[0] = 16'h0000;
    rd_m[1] = 16'h0000;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid[1] | mem_we[1];
    end
    check("mid_rst_quiet", seen, 0);
    mon_en = 1;
    @(negedge clk);
    issue(1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0);   // recovery after reset

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
